// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, widths and the troop growth rule for the round scheduler
package game_pkg;

  localparam int LOG2_BORAD_WIDTH = 4;
  localparam int LOG2_PLAYER_CNT  = 3;
  localparam int PLAYER_CNT       = 2;
  localparam int LOG2_MAX_TROOP   = 9;
  localparam int LOG2_MAX_ROUND   = 12;

  typedef enum logic [LOG2_PLAYER_CNT-1:0] {
    NPC  = 3'd0,
    RED  = 3'd1,
    BLUE = 3'd2
  } player_t;

  typedef enum logic [1:0] {
    TERRITORY = 2'd0,
    MOUNTAIN  = 2'd1,
    CROWN     = 2'd2,
    CITY      = 2'd3
  } cell_t;

  typedef struct packed {
    player_t                   owner;
    cell_t                     kind;
    logic [LOG2_MAX_TROOP-1:0] troop;
  } cell_s;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_NEXT,
    S_GROW_RD,
    S_GROW_WR,
    S_HALT
  } state_t;

  // Troop count after one growth step; NPC and mountain cells never grow,
  // territory grows only on period rounds, and the count saturates.
  function automatic logic [LOG2_MAX_TROOP-1:0] grow_troop(input cell_s c, input logic territory_due);
    logic bump;
    bump = 1'b0;
    if (c.owner != NPC) begin
      case (c.kind)
        CROWN, CITY: bump = 1'b1;
        TERRITORY:   bump = territory_due;
        default:     bump = 1'b0;
      endcase
    end
    if (bump && (c.troop != '1)) begin
      return c.troop + LOG2_MAX_TROOP'(1);
    end
    return c.troop;
  endfunction

endpackage

// File: rtl/game_round_scheduler_if.sv
// rtl/game_round_scheduler_if.sv - single-port cell-storage bus between scheduler and cell array
interface game_round_scheduler_if;
  import game_pkg::*;

  logic [LOG2_BORAD_WIDTH-1:0] cell_h;
  logic [LOG2_BORAD_WIDTH-1:0] cell_v;
  logic                        cell_rd_en;
  logic [LOG2_PLAYER_CNT-1:0]  cell_owner_in;
  logic [1:0]                  cell_type_in;
  logic [LOG2_MAX_TROOP-1:0]   cell_troop_in;
  logic                        cell_wr_en;
  logic [LOG2_MAX_TROOP-1:0]   cell_troop_out;

  modport master (
    output cell_h, cell_v, cell_rd_en, cell_wr_en, cell_troop_out,
    input  cell_owner_in, cell_type_in, cell_troop_in
  );

  modport slave (
    input  cell_h, cell_v, cell_rd_en, cell_wr_en, cell_troop_out,
    output cell_owner_in, cell_type_in, cell_troop_in
  );

endinterface

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn down-counter, loaded on turn entry, flags expiry at zero
module turn_timer #(
  parameter int CYCLES = 100_000_000
)(
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int TIMER_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [TIMER_W-1:0] count;

  // Reload on turn entry, otherwise count down while the turn runs.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= TIMER_W'(CYCLES - 1);
    end else if (enable && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expire = enable && (count == '0);

endmodule

// File: rtl/game_round_scheduler.sv
// rtl/game_round_scheduler.sv - turn/round sequencer with troop-growth sweep; optional GAME_TURN_TIMEOUT_EN turn timer
module game_round_scheduler
  import game_pkg::*;
#(
  parameter int BORAD_WIDTH      = 10,
  parameter int TERRITORY_PERIOD = 25
`ifdef GAME_TURN_TIMEOUT_EN
  , parameter int TURN_TIMEOUT_CYCLES = 100_000_000
`endif
)(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       move_done,
  input  logic                       game_over,
  game_round_scheduler_if.master     cell_bus,
  output logic [LOG2_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_ROUND:0]    round,
  output logic                       turn_active,
  output logic                       turn_timeout
);

  localparam logic [LOG2_BORAD_WIDTH-1:0] LAST_COORD = LOG2_BORAD_WIDTH'(BORAD_WIDTH - 1);
  localparam int                  PHASE_W    = (TERRITORY_PERIOD > 1) ? $clog2(TERRITORY_PERIOD) : 1;
  localparam logic [PHASE_W-1:0]  PHASE_LAST = PHASE_W'(TERRITORY_PERIOD - 1);
  localparam logic [PHASE_W-1:0]  PHASE_INIT = (TERRITORY_PERIOD > 1) ? PHASE_W'(1) : PHASE_W'(0);
  localparam player_t             LAST_PLAYER = player_t'(PLAYER_CNT);

  state_t                      state;
  state_t                      next_state;
  player_t                     player;
  logic [PHASE_W-1:0]          phase;
  logic [LOG2_BORAD_WIDTH-1:0] h;
  logic [LOG2_BORAD_WIDTH-1:0] v;
  cell_s                       rd_cell;
  logic [LOG2_MAX_TROOP-1:0]   new_troop;
  logic                        troop_changed;
  logic                        last_cell;
  logic                        timeout;

`ifdef GAME_TURN_TIMEOUT_EN
  logic timer_load;

  assign timer_load = (state != S_TURN) && (next_state == S_TURN);

  turn_timer #(
    .CYCLES (TURN_TIMEOUT_CYCLES)
  ) u_turn_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (timer_load),
    .enable (state == S_TURN),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign last_cell = (h == LAST_COORD) && (v == LAST_COORD);

  // Decode the read data and compute the grown troop; write only on change.
  always_comb begin
    rd_cell       = '{owner: player_t'(cell_bus.cell_owner_in),
                      kind:  cell_t'(cell_bus.cell_type_in),
                      troop: cell_bus.cell_troop_in};
    new_troop     = grow_troop(rd_cell, phase == '0);
    troop_changed = (state == S_GROW_WR) && (new_troop != rd_cell.troop);
  end

  assign cell_bus.cell_h         = h;
  assign cell_bus.cell_v         = v;
  assign cell_bus.cell_rd_en     = (state == S_GROW_RD);
  assign cell_bus.cell_wr_en     = troop_changed;
  assign cell_bus.cell_troop_out = troop_changed ? new_troop : '0;
  assign current_player          = player;
  assign turn_active             = (state == S_TURN);
  assign turn_timeout            = timeout;

  // Next-state decode; game_over overrides every other transition.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_TURN;
      S_TURN:    if (move_done || timeout) next_state = S_NEXT;
      S_NEXT:    next_state = (player == LAST_PLAYER) ? S_GROW_RD : S_TURN;
      S_GROW_RD: next_state = S_GROW_WR;
      S_GROW_WR: next_state = last_cell ? S_TURN : S_GROW_RD;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_IDLE;
    endcase
    if (game_over) next_state = S_HALT;
  end

  // State register plus player rotation, sweep address and round bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      player <= RED;
      round  <= (LOG2_MAX_ROUND + 1)'(1);
      phase  <= PHASE_INIT;
      h      <= '0;
      v      <= '0;
    end else begin
      state <= next_state;
      if (!game_over) begin
        case (state)
          S_NEXT: begin
            if (player == LAST_PLAYER) begin
              h <= '0;
              v <= '0;
            end else begin
              player <= player_t'(player + LOG2_PLAYER_CNT'(1));
            end
          end
          S_GROW_WR: begin
            if (h == LAST_COORD) begin
              h <= '0;
              if (v == LAST_COORD) begin
                v      <= '0;
                player <= RED;
                if (round != '1) begin
                  round <= round + (LOG2_MAX_ROUND + 1)'(1);
                  phase <= (phase == PHASE_LAST) ? PHASE_W'(0) : phase + PHASE_W'(1);
                end
              end else begin
                v <= v + LOG2_BORAD_WIDTH'(1);
              end
            end else begin
              h <= h + LOG2_BORAD_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_round_scheduler.sv
// tb/tb_game_round_scheduler.sv - directed self-checking bench for game_round_scheduler (3x3 board, period 2)
module tb_game_round_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        move_done;
  logic        game_over;
  logic [2:0]  current_player;
  logic [12:0] round;
  logic        turn_active;
  logic        turn_timeout;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int wr_count = 0;

  // 3x3 board, row-major index v*3+h. Types: 0 TERRITORY, 1 MOUNTAIN, 2 CROWN, 3 CITY.
  logic [2:0] m_owner [9] = '{3'd1, 3'd0, 3'd1, 3'd2, 3'd1, 3'd2, 3'd0, 3'd2, 3'd1};
  logic [1:0] m_type  [9] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd2};
  logic [8:0] m_troop [9] = '{9'd43, 9'd40, 9'd7, 9'd511, 9'd5, 9'd0, 9'd0, 9'd100, 9'd10};

  game_round_scheduler_if bus();

  game_round_scheduler #(
    .BORAD_WIDTH      (3),
    .TERRITORY_PERIOD (2)
`ifdef GAME_TURN_TIMEOUT_EN
    , .TURN_TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .move_done      (move_done),
    .game_over      (game_over),
    .cell_bus       (bus.master),
    .current_player (current_player),
    .round          (round),
    .turn_active    (turn_active),
    .turn_timeout   (turn_timeout)
  );

  always #5 clock = ~clock;

  // Cell array model: one-cycle read latency, troop write-back.
  always @(posedge clock) begin
    automatic int idx = int'(bus.cell_v) * 3 + int'(bus.cell_h);
    if (bus.cell_rd_en && idx < 9) begin
      bus.cell_owner_in <= m_owner[idx];
      bus.cell_type_in  <= m_type[idx];
      bus.cell_troop_in <= m_troop[idx];
      rd_count <= rd_count + 1;
    end
    if (bus.cell_wr_en && idx < 9) begin
      m_troop[idx] <= bus.cell_troop_out;
      wr_count <= wr_count + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_move();
    move_done = 1'b1;
    step();
    move_done = 1'b0;
  endtask

  // From NEXT (last player), clock until TURN returns; optionally poke move_done mid-sweep.
  task automatic run_sweep(input logic poke, output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      move_done = poke && (i == 5);
      step();
      cycles++;
      if (turn_active) break;
    end
    move_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_h"},        32'(bus.cell_h), 0);
    check({tag, "_v"},        32'(bus.cell_v), 0);
    check({tag, "_rd"},       32'(bus.cell_rd_en), 0);
    check({tag, "_wr"},       32'(bus.cell_wr_en), 0);
    check({tag, "_tout"},     32'(bus.cell_troop_out), 0);
    check({tag, "_player"},   32'(current_player), 1);
    check({tag, "_round"},    32'(round), 1);
    check({tag, "_active"},   32'(turn_active), 0);
    check({tag, "_timeout"},  32'(turn_timeout), 0);
  endtask

  initial begin
    int cyc;
    int rd_snap;
    int wr_snap;

    reset = 1'b1; start = 1'b0; move_done = 1'b0; game_over = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b0;

    // move_done in IDLE is ignored
    pulse_move();
    check("idle_move_ignored", 32'(turn_active), 0);

    // start -> RED's turn; a second start inside TURN does nothing
    start = 1'b1; step(); start = 1'b0;
    check("turn_red_active", 32'(turn_active), 1);
    check("turn_red_player", 32'(current_player), 1);
    start = 1'b1; step(); start = 1'b0;
    check("turn_start_ignored", 32'(turn_active), 1);

    // Round 1: RED -> BLUE -> sweep
    pulse_move();
    check("next_inactive", 32'(turn_active), 0);
    step();
    check("turn_blue_player", 32'(current_player), 2);
    check("turn_blue_active", 32'(turn_active), 1);
    pulse_move();
    rd_snap = rd_count; wr_snap = wr_count;
    run_sweep(1'b1, cyc);
    // 1 clock NEXT->GROW_RD plus 18 sweep clocks
    check("sweep1_cycles", 32'(cyc), 19);
    check("sweep1_reads", 32'(rd_count - rd_snap), 9);
    check("sweep1_writes", 32'(wr_count - wr_snap), 3);
    check("sweep1_round", 32'(round), 2);
    check("sweep1_player", 32'(current_player), 1);
    check("red_city", 32'(m_troop[0]), 44);
    check("npc_city", 32'(m_troop[1]), 40);
    check("mountain", 32'(m_troop[2]), 7);
    check("crown_sat", 32'(m_troop[3]), 511);
    check("terr_r1", 32'(m_troop[4]), 5);
    check("blue_city", 32'(m_troop[5]), 1);
    check("blue_terr_r1", 32'(m_troop[7]), 100);
    check("red_crown", 32'(m_troop[8]), 11);

    // Round 2: closing an even round grows owned territory
    pulse_move(); step(); pulse_move();
    rd_snap = rd_count; wr_snap = wr_count;
    run_sweep(1'b0, cyc);
    check("sweep2_cycles", 32'(cyc), 19);
    check("sweep2_reads", 32'(rd_count - rd_snap), 9);
    check("sweep2_writes", 32'(wr_count - wr_snap), 5);
    check("sweep2_round", 32'(round), 3);
    check("terr_r2", 32'(m_troop[4]), 6);
    check("blue_terr_r2", 32'(m_troop[7]), 101);
    check("npc_terr_r2", 32'(m_troop[6]), 0);
    check("crown_sat_r2", 32'(m_troop[3]), 511);

    // Round 3: game_over while addressing cell (1,0)
    pulse_move(); step(); pulse_move();
    step();
    for (int i = 0; i < 10; i++) begin
      if (bus.cell_h == 4'd1 && bus.cell_v == 4'd0) break;
      step();
    end
    check("halt_pos_h", 32'(bus.cell_h), 1);
    check("halt_pos_rd", 32'(bus.cell_rd_en), 1);
    game_over = 1'b1;
    step();
    rd_snap = rd_count; wr_snap = wr_count;
    check("halt_rd", 32'(bus.cell_rd_en), 0);
    check("halt_wr", 32'(bus.cell_wr_en), 0);
    check("halt_active", 32'(turn_active), 0);
    start = 1'b1; move_done = 1'b1;
    step(); step(); step();
    start = 1'b0; move_done = 1'b0; game_over = 1'b0;
    step(); step();
    check("halt_no_reads", 32'(rd_count - rd_snap), 0);
    check("halt_no_writes", 32'(wr_count - wr_snap), 0);
    check("halt_stays", 32'(turn_active), 0);
    check("halt_round", 32'(round), 3);
    check("halt_write_stands", 32'(m_troop[0]), 46);
    check("halt_cell1_untouched", 32'(m_troop[1]), 40);

    // Only reset leaves HALT
    reset = 1'b1; step(); reset = 1'b0;
    check_reset_outputs("halt_reset");
    step();
    check("idle_after_reset", 32'(turn_active), 0);
    start = 1'b1; step(); start = 1'b0;
    check("restart_active", 32'(turn_active), 1);

    // Reset while in GROW_WR at (1,1)
    pulse_move(); step(); pulse_move();
    for (int i = 0; i < 30; i++) begin
      if (bus.cell_h == 4'd1 && bus.cell_v == 4'd1 && !bus.cell_rd_en && !turn_active) break;
      step();
    end
    check("grow_wr_pos_v", 32'(bus.cell_v), 1);
    reset = 1'b1; step(); reset = 1'b0;
    check_reset_outputs("midsweep_reset");

    start = 1'b1; step(); start = 1'b0;
`ifdef GAME_TURN_TIMEOUT_EN
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (turn_timeout) break;
      step();
      cyc++;
    end
    // First TURN cycle observed above; pulse lands in the 8th TURN cycle
    check("timeout_delay", 32'(cyc), 7);
    check("timeout_player", 32'(current_player), 1);
    step();
    check("timeout_next", 32'(turn_active), 0);
    check("timeout_pulse_width", 32'(turn_timeout), 0);
    step();
    check("timeout_advance", 32'(current_player), 2);
    repeat (7) step();
    check("timeout_blue_pulse", 32'(turn_timeout), 1);
    move_done = 1'b1; step(); move_done = 1'b0;
    check("both_end_next", 32'(turn_active), 0);
    step();
    check("both_end_single", 32'(bus.cell_rd_en), 1);
    check("both_end_h", 32'(bus.cell_h), 0);
`else
    for (int i = 0; i < 20; i++) begin
      check("no_timeout", 32'(turn_timeout), 0);
      step();
    end
    check("turn_holds", 32'(turn_active), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
